// File: rtl/io_map_pkg.sv
// Shared address map, control bits and timer encoding
// for the memory-mapped I/O responder slice.
`timescale 1ns/1ps
package io_map_pkg;

  localparam logic [15:0] IO_BASE_DEF = 16'hFF00;

  localparam logic [2:0] IO_STATUS  = 3'd0;
  localparam logic [2:0] IO_KEYDATA = 3'd1;
  localparam logic [2:0] IO_LEDS    = 3'd2;
  localparam logic [2:0] IO_TIMER   = 3'd3;
  localparam logic [2:0] IO_CTRL    = 3'd4;

  localparam int CTRL_CLR_EXP = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_FLUSH   = 2;

  typedef enum logic [1:0] {
    TMR_IDLE    = 2'd0,
    TMR_RUN     = 2'd1,
    TMR_EXPIRED = 2'd2
  } tmr_state_e;

  function automatic logic in_window(
    input logic [15:0] a,
    input logic [15:0] base
  );
    return a[15:3] == base[15:3];
  endfunction

endpackage

// File: rtl/io_key_fifo.sv
// Key-event FIFO: DEPTH entries of W bits, flush wins over push/pop.
// Ports: i_push/i_data, i_pop, i_flush; o_full, o_empty, o_head, o_count.
`timescale 1ns/1ps
module io_key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;

  // A full FIFO still takes a push when a pop frees the slot this cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush)
      r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push)
        r_wp <= r_wp + 1'b1;
      if (w_do_pop)
        r_rp <= r_rp + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_bus_responder.sv
// I/O responder at BASE..BASE+7: key FIFO, LED register, countdown timer.
// Ports: bus strobes/adr/writedata in; memdata/hit (registered), leds, irq out.
`timescale 1ns/1ps
module io_bus_responder
  import io_map_pkg::*;
#(
  parameter logic [15:0] BASE       = IO_BASE_DEF,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TICK_DIV   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] adr,
  input  logic [15:0] writedata,
  input  logic [3:0]  keys,
  output logic [15:0] memdata,
  output logic        hit,
  output logic [15:0] leds,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          w_win;
  logic          w_rd;
  logic          w_wr;
  logic [2:0]    w_off;
  logic          w_pop;
  logic          w_flush;
  logic          w_clr_exp;
  logic          w_clr_ovf;
  logic          w_tmr_wr;
  logic          w_tick;
  logic          w_expired;
  logic          w_running;
  logic [15:0]   w_rdata;

  logic [3:0]    w_knew;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_ne;
  logic          w_drop;
  logic [3:0]    w_head;
  logic [CW-1:0] w_count;

  logic [3:0]    r_ks1;
  logic [3:0]    r_ks2;
  logic [3:0]    r_kprev;
  logic          r_ovf;
  logic [15:0]   r_memdata;
  logic          r_hit;
  logic [15:0]   r_leds;
  logic [15:0]   r_count;
  logic [PW-1:0] r_presc;

  tmr_state_e    r_tstate;
  tmr_state_e    w_tnext;

  // Decode: a simultaneous read and write is treated as a write only.
  assign w_win = in_window(adr, BASE);
  assign w_off = adr[2:0];
  assign w_wr  = memwrite & w_win;
  assign w_rd  = memread & ~memwrite & w_win;

  assign w_pop     = w_rd & (w_off == IO_KEYDATA) & ~w_empty;
  assign w_tmr_wr  = w_wr & (w_off == IO_TIMER);
  assign w_clr_exp = w_wr & (w_off == IO_CTRL) & writedata[CTRL_CLR_EXP];
  assign w_clr_ovf = w_wr & (w_off == IO_CTRL) & writedata[CTRL_CLR_OVF];
  assign w_flush   = w_wr & (w_off == IO_CTRL) & writedata[CTRL_FLUSH];

  // Keys: two-flop synchronizer, then rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ks1   <= '0;
      r_ks2   <= '0;
      r_kprev <= '0;
    end else begin
      r_ks1   <= keys;
      r_ks2   <= r_ks1;
      r_kprev <= r_ks2;
    end
  end

  assign w_knew = r_ks2 & ~r_kprev;
  assign w_push = |w_knew;

  io_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (4)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_knew),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_ne   = w_count != '0;
  assign w_drop = w_push & w_full & ~w_pop & ~w_flush;

  // Overflow is sticky; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (w_clr_ovf)
      r_ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_leds <= '0;
    else if (w_wr && w_off == IO_LEDS)
      r_leds <= writedata;
  end

  // Timer FSM: state register.
  always_ff @(posedge clk) begin
    if (rst)
      r_tstate <= TMR_IDLE;
    else
      r_tstate <= w_tnext;
  end

  // Timer FSM: next state. A load wins in every state.
  always_comb begin
    w_tnext = r_tstate;
    if (w_tmr_wr) begin
      w_tnext = (writedata == 16'd0) ? TMR_EXPIRED : TMR_RUN;
    end else begin
      unique case (r_tstate)
        TMR_RUN:
          if (w_tick && r_count == 16'd1)
            w_tnext = TMR_EXPIRED;
        TMR_EXPIRED:
          if (w_clr_exp)
            w_tnext = TMR_IDLE;
        default: ;
      endcase
    end
  end

  // Timer FSM: outputs.
  always_comb begin
    w_running = 1'b0;
    w_expired = 1'b0;
    unique case (r_tstate)
      TMR_RUN:     w_running = 1'b1;
      TMR_EXPIRED: w_expired = 1'b1;
      default: ;
    endcase
  end

  assign w_tick = w_running & (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_presc <= '0;
    end else if (w_tmr_wr) begin
      r_count <= writedata;
      r_presc <= '0;
    end else if (w_running) begin
      if (w_tick) begin
        r_presc <= '0;
        r_count <= r_count - 16'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Read mux sees pre-update state of this cycle.
  always_comb begin
    w_rdata = '0;
    unique case (w_off)
      IO_STATUS:  w_rdata = {12'b0, r_ovf, w_expired, w_full, w_ne};
      IO_KEYDATA: w_rdata = w_empty ? 16'd0 : {12'b0, w_head};
      IO_LEDS:    w_rdata = r_leds;
      IO_TIMER:   w_rdata = r_count;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_memdata <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_hit <= w_rd;
      if (w_rd)
        r_memdata <= w_rdata;
    end
  end

  assign memdata = r_memdata;
  assign hit     = r_hit;
  assign leds    = r_leds;
  assign irq     = w_ne | w_expired;

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed + randomized bench for io_bus_responder against a
// queue/arithmetic model of the key FIFO, LEDs and timer.
`timescale 1ns/1ps
module tb_io_bus_responder;

  localparam int TD    = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [15:0] adr;
  logic [15:0] writedata;
  logic [3:0]  keys;
  logic [15:0] memdata;
  logic        hit;
  logic [15:0] leds;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0]  mq[$];
  logic        m_ovf;
  logic        m_exp;
  logic [3:0]  m_keys;
  logic [15:0] rd;
  logic        rh;

  always #5 clk = ~clk;

  io_bus_responder #(
    .BASE       (16'hFF00),
    .FIFO_DEPTH (DEPTH),
    .TICK_DIV   (TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .keys      (keys),
    .memdata   (memdata),
    .hit       (hit),
    .leds      (leds),
    .irq       (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    adr = a;
    writedata = d;
    memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    adr = a;
    memread = 1'b1;
    tick();
    memread = 1'b0;
    rd = memdata;
    rh = hit;
  endtask

  function automatic logic [15:0] m_status();
    return {12'b0, m_ovf, m_exp, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  // Apply a key level and let it settle; model pushes the rising mask.
  task automatic press(input logic [3:0] v);
    logic [3:0] mask;
    mask = v & ~m_keys;
    m_keys = v;
    keys = v;
    if (mask != 0) begin
      if (mq.size() < DEPTH) mq.push_back(mask);
      else m_ovf = 1'b1;
    end
    repeat (4) tick();
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] e;
    e = (mq.size() != 0) ? {12'b0, mq.pop_front()} : 16'h0;
    bus_rd(16'hFF01);
    chk(tag, rd, e);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] last;
    logic [3:0]  k;
    int          m;
    int          rem;

    rst = 1'b1;
    memread = 1'b0;
    memwrite = 1'b0;
    adr = '0;
    writedata = '0;
    keys = '0;
    m_ovf = 1'b0;
    m_exp = 1'b0;
    m_keys = '0;
    repeat (2) tick();
    chk("rst_memdata", memdata, 16'h0);
    chk("rst_hit", {15'b0, hit}, 16'h0);
    chk("rst_leds", leds, 16'h0);
    chk("rst_irq", {15'b0, irq}, 16'h0);
    rst = 1'b0;
    tick();
    bus_rd(16'hFF00);
    chk("rst_status", rd, 16'h0);
    chk("rst_status_hit", {15'b0, rh}, 16'h1);

    bus_wr(16'hFF02, 16'hA5C3);
    chk("leds_out", leds, 16'hA5C3);
    bus_rd(16'hFF02);
    chk("leds_rd", rd, 16'hA5C3);
    chk("leds_hit", {15'b0, rh}, 16'h1);

    press(4'b0010);
    press(4'b0000);
    press(4'b1000);
    press(4'b0000);
    bus_rd(16'hFF00);
    chk("keys_status", rd, m_status());
    chk("keys_irq", {15'b0, irq}, 16'h1);
    pop_chk("keys_pop0");
    pop_chk("keys_pop1");
    pop_chk("keys_empty");
    bus_rd(16'hFF00);
    chk("keys_status_empty", rd, m_status());

    for (int i = 0; i < 9; i++) begin
      press(4'($urandom_range(1, 15)));
      press(4'b0000);
    end
    bus_rd(16'hFF00);
    chk("ovf_status", rd, 16'h000B);
    bus_wr(16'hFF04, 16'h0002);
    m_ovf = 1'b0;
    bus_rd(16'hFF00);
    chk("ovf_cleared", rd, m_status());
    for (int i = 0; i < DEPTH; i++)
      pop_chk($sformatf("ovf_pop%0d", i));
    pop_chk("ovf_empty");

    bus_rd(16'hFF02);
    last = rd;
    bus_rd(16'hFF07);
    chk("rd_ff07", rd, 16'h0);
    chk("rd_ff07_hit", {15'b0, rh}, 16'h1);
    bus_rd(16'hFF05);
    last = rd;
    bus_wr(16'h1234, 16'hFFFF);
    chk("oow_wr_leds", leds, 16'hA5C3);
    bus_rd(16'h1234);
    chk("oow_hit", {15'b0, rh}, 16'h0);
    chk("oow_memdata", rd, last);

    for (int i = 0; i < DEPTH; i++) begin
      press(4'($urandom_range(1, 15)));
      press(4'b0000);
    end
    bus_rd(16'hFF00);
    chk("pp_full_status", rd, 16'h0003);
    k = 4'($urandom_range(1, 15));
    keys = k;
    tick();
    tick();
    v = {12'b0, mq.pop_front()};
    mq.push_back(k);
    m_keys = k;
    bus_rd(16'hFF01);
    chk("pp_head", rd, v);
    bus_rd(16'hFF00);
    chk("pp_status", rd, 16'h0003);
    press(4'b0000);
    for (int i = 0; i < DEPTH; i++)
      pop_chk($sformatf("pp_pop%0d", i));
    pop_chk("pp_empty");

    press(4'b0101);
    press(4'b0000);
    bus_wr(16'hFF04, 16'h0004);
    mq.delete();
    bus_rd(16'hFF00);
    chk("flush_status", rd, m_status());
    pop_chk("flush_empty");

    bus_wr(16'hFF03, 16'd3);
    repeat (11) tick();
    chk("tmr_pre_irq", {15'b0, irq}, 16'h0);
    tick();
    chk("tmr_irq", {15'b0, irq}, 16'h1);
    m_exp = 1'b1;
    bus_rd(16'hFF03);
    chk("tmr_count0", rd, 16'h0);
    bus_rd(16'hFF00);
    chk("tmr_status", rd, m_status());
    bus_wr(16'hFF04, 16'h0001);
    m_exp = 1'b0;
    chk("tmr_clr_irq", {15'b0, irq}, 16'h0);
    repeat (20) tick();
    chk("tmr_idle_irq", {15'b0, irq}, 16'h0);
    bus_rd(16'hFF00);
    chk("tmr_idle_status", rd, 16'h0);

    for (int i = 0; i < 3; i++) begin
      v = 16'($urandom_range(1, 6));
      m = $urandom_range(1, int'(v) * TD);
      bus_wr(16'hFF03, v);
      repeat (m - 1) tick();
      bus_rd(16'hFF03);
      chk($sformatf("tmr_rnd_cnt%0d", i), rd, v - 16'((m - 1) / TD));
      rem = int'(v) * TD - m;
      if (rem > 0) begin
        repeat (rem - 1) tick();
        chk($sformatf("tmr_rnd_pre%0d", i), {15'b0, irq}, 16'h0);
        tick();
      end
      chk($sformatf("tmr_rnd_irq%0d", i), {15'b0, irq}, 16'h1);
      bus_wr(16'hFF04, 16'h0001);
    end

    bus_wr(16'hFF03, 16'd0);
    bus_rd(16'hFF00);
    chk("tmr_zero_status", rd, 16'h0004);
    bus_wr(16'hFF04, 16'h0001);

    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      bus_wr(16'hFF02, v);
      bus_rd(16'hFF02);
      chk($sformatf("leds_rnd%0d", i), rd, v);
      bus_rd(16'hFF05 + 16'($urandom_range(0, 2)));
      chk($sformatf("rsv_rnd%0d", i), rd, 16'h0);
    end

    bus_wr(16'hFF03, 16'd50);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_exp = 1'b0;
    chk("rst_mid_leds", leds, 16'h0);
    bus_rd(16'hFF03);
    chk("rst_mid_count", rd, 16'h0);
    repeat (250) tick();
    chk("rst_mid_irq", {15'b0, irq}, 16'h0);
    bus_rd(16'hFF00);
    chk("rst_mid_status", rd, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
